// File: rtl/fifo_fwft_axis.sv
// fifo_fwft_axis: synchronous first-word-fall-through FIFO, valid/ready on both sides, RAM plus output register.
// Optional high-water mark is built only when FIFO_HWM_EN is defined; otherwise o_hwm is tied to zero.
module fifo_fwft_axis #(
  parameter int FIFO_WIDTH    = 32,
  parameter int FIFO_ADDR_SZ  = 4,
  parameter int AFULL_THRESH  = (1 << FIFO_ADDR_SZ) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic [FIFO_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [FIFO_WIDTH-1:0]   m_data,
  input  logic                    m_ready,
  output logic [FIFO_ADDR_SZ:0]   o_count,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  input  logic                    i_hwm_clr,
  output logic [FIFO_ADDR_SZ:0]   o_hwm
);

  localparam int                    DEPTH    = 1 << FIFO_ADDR_SZ;
  localparam logic [FIFO_ADDR_SZ:0] DEPTH_V  = (FIFO_ADDR_SZ+1)'(DEPTH);
  localparam logic [FIFO_ADDR_SZ:0] ONE_V    = (FIFO_ADDR_SZ+1)'(1);
  localparam logic [FIFO_ADDR_SZ:0] ZERO_V   = (FIFO_ADDR_SZ+1)'(0);
  localparam logic [FIFO_ADDR_SZ:0] AFULL_V  = (FIFO_ADDR_SZ+1)'(AFULL_THRESH);
  localparam logic [FIFO_ADDR_SZ:0] AEMPTY_V = (FIFO_ADDR_SZ+1)'(AEMPTY_THRESH);

  logic [FIFO_WIDTH-1:0]   mem_r [DEPTH];
  logic [FIFO_ADDR_SZ:0]   wr_addr_r;
  logic [FIFO_ADDR_SZ:0]   rd_addr_r;
  logic                    m_valid_r;
  logic [FIFO_WIDTH-1:0]   m_data_r;

  logic [FIFO_ADDR_SZ:0]   occ_s;
  logic [FIFO_ADDR_SZ:0]   count_s;
  logic                    ram_full_s;
  logic                    ram_empty_s;
  logic                    accept_s;
  logic                    load_s;

  // The extra wrap bit makes the pointer difference a full 0..DEPTH occupancy.
  assign occ_s       = wr_addr_r - rd_addr_r;
  assign ram_full_s  = (occ_s == DEPTH_V);
  assign ram_empty_s = (occ_s == ZERO_V);
  assign accept_s    = s_valid && !ram_full_s;
  assign load_s      = !ram_empty_s && (!m_valid_r || m_ready);
  assign count_s     = occ_s + {{FIFO_ADDR_SZ{1'b0}}, m_valid_r};

  assign s_ready        = !ram_full_s;
  assign m_valid        = m_valid_r;
  assign m_data         = m_data_r;
  assign o_count        = count_s;
  assign o_almost_full  = (count_s >= AFULL_V);
  assign o_almost_empty = (count_s <= AEMPTY_V);

  // Storage array: write-only port, contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_addr_r[FIFO_ADDR_SZ-1:0]] <= s_data;
    end
  end

  // Pointers and output register; the registered RAM read lands directly in m_data_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_r <= ZERO_V;
      rd_addr_r <= ZERO_V;
      m_valid_r <= 1'b0;
      m_data_r  <= {FIFO_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        wr_addr_r <= wr_addr_r + ONE_V;
      end
      if (load_s) begin
        m_data_r  <= mem_r[rd_addr_r[FIFO_ADDR_SZ-1:0]];
        rd_addr_r <= rd_addr_r + ONE_V;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

`ifdef FIFO_HWM_EN
  logic [FIFO_ADDR_SZ:0] hwm_r;

  // High-water mark; a clear reloads the current fill level and wins over a new peak.
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_r <= ZERO_V;
    end else if (i_hwm_clr) begin
      hwm_r <= count_s;
    end else if (count_s > hwm_r) begin
      hwm_r <= count_s;
    end
  end

  assign o_hwm = hwm_r;
`else
  logic unused_hwm_clr_s;

  assign unused_hwm_clr_s = i_hwm_clr;
  assign o_hwm            = ZERO_V;
`endif

endmodule

// File: tb/tb_fifo_fwft_axis.sv
// tb_fifo_fwft_axis: randomized/directed bench for fifo_fwft_axis against a queue-based reference model.
// Builds with or without FIFO_HWM_EN; high-water mark checks follow the macro.
module tb_fifo_fwft_axis;

  localparam int W     = 8;
  localparam int A     = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic [W-1:0]  s_data;
  logic          s_ready;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
  logic [A:0]    o_count;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic          i_hwm_clr;
  logic [A:0]    o_hwm;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words waiting in RAM, plus the output register.
  logic [W-1:0]  ram_q[$];
  bit            mv;
  logic [W-1:0]  md;
  int            hwm;
  bit            last_acc;
  int            cyc = 0;
  logic [W-1:0]  cons_q[$];
  int            cons_cyc[$];

  fifo_fwft_axis #(
    .FIFO_WIDTH(W), .FIFO_ADDR_SZ(A), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .o_count(o_count), .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .i_hwm_clr(i_hwm_clr), .o_hwm(o_hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mcount();
    return ram_q.size() + (mv ? 1 : 0);
  endfunction

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    int cnt;
    bit acc;
    bit ld;
    @(negedge clk);
    chk("s_ready", s_ready, ram_q.size() != DEPTH);
    chk("m_valid", m_valid, mv);
    chk("m_data", m_data, md);
    chk("o_count", o_count, mcount());
    chk("almost_full", o_almost_full, mcount() >= AF);
    chk("almost_empty", o_almost_empty, mcount() <= AE);
`ifdef FIFO_HWM_EN
    chk("o_hwm", o_hwm, hwm);
`else
    chk("o_hwm", o_hwm, 0);
`endif
    if (m_valid && m_ready && !reset) begin
      cons_q.push_back(m_data);
      cons_cyc.push_back(cyc);
    end
    @(posedge clk);
    cnt = mcount();
    acc = s_valid && (ram_q.size() != DEPTH);
    ld  = (ram_q.size() != 0) && (!mv || m_ready);
    if (reset) begin
      ram_q.delete();
      mv  = 1'b0;
      md  = '0;
      hwm = 0;
      acc = 1'b0;
    end else begin
      if (i_hwm_clr) hwm = cnt;
      else if (cnt > hwm) hwm = cnt;
      if (ld) begin
        md = ram_q.pop_front();
        mv = 1'b1;
      end else if (mv && m_ready) begin
        mv = 1'b0;
      end
      if (acc) ram_q.push_back(s_data);
    end
    last_acc = acc;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    step();
    reset = 1'b0;
    cons_q.delete();
    cons_cyc.delete();
  endtask

  // ready_mode: 0 = consumer stalled, 1 = always ready, 2 = random valid/ready.
  task automatic feed(input int ncyc, input int nwords, input logic [W-1:0] base,
                      input int ready_mode, inout int n_acc);
    for (int c = 0; c < ncyc; c++) begin
      s_valid = (n_acc < nwords) && (ready_mode != 2 || $urandom_range(0, 3) != 0);
      s_data  = base + W'(n_acc);
      if (ready_mode == 2) m_ready = ($urandom_range(0, 2) != 0);
      else                 m_ready = (ready_mode == 1);
      step();
      if (last_acc) n_acc++;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int n;
    int c0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; i_hwm_clr = 1'b0;
    mv = 1'b0; md = '0; hwm = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single word latency
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    chk("single_early_valid", m_valid, 0);
    step();
    chk("single_valid", m_valid, 1);
    chk("single_data", m_data, 8'hA5);
    chk("single_count", o_count, 1);
    chk("single_aempty", o_almost_empty, 1);
    step();

    // Fill to capacity, then drain
    do_reset();
    n = 0;
    feed(10, 6, 8'h01, 0, n);
    chk("fill_accepted", n, 5);
    chk("fill_count", o_count, 5);
    chk("fill_afull", o_almost_full, 1);
    chk("fill_sready", s_ready, 0);
    feed(15, 6, 8'h01, 1, n);
    chk("drain_accepted", n, 6);
    chk("drain_count", o_count, 0);
    chk("drain_len", cons_q.size(), 6);
    for (int i = 0; i < cons_q.size(); i++) chk("drain_word", cons_q[i], i + 1);
    for (int i = 1; i < cons_cyc.size() && i < 5; i++) chk("drain_gap", cons_cyc[i], cons_cyc[0] + i);

    // Streaming through several pointer wraps
    do_reset();
    n = 0;
    c0 = cyc;
    feed(24, 20, 8'h00, 1, n);
    chk("stream_len", cons_q.size(), 20);
    if (cons_cyc.size() > 0) chk("stream_latency", cons_cyc[0], c0 + 2);
    for (int i = 0; i < cons_q.size(); i++) begin
      chk("stream_word", cons_q[i], i);
      chk("stream_gap", cons_cyc[i], cons_cyc[0] + i);
    end

    // Random backpressure
    do_reset();
    n = 0;
    feed(400, 50, 8'h40, 2, n);
    feed(20, 50, 8'h40, 1, n);
    chk("bp_accepted", n, 50);
    chk("bp_len", cons_q.size(), 50);
    for (int i = 0; i < cons_q.size(); i++) chk("bp_word", cons_q[i], 8'h40 + i);

    // Reset with words in flight
    do_reset();
    n = 0;
    feed(5, 3, 8'hB0, 0, n);
    chk("pre_reset_count", o_count, 3);
    do_reset();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_s_ready", s_ready, 1);
    n = 0;
    feed(10, 4, 8'hC0, 1, n);
    chk("post_rst_len", cons_q.size(), 4);
    for (int i = 0; i < cons_q.size(); i++) chk("post_rst_word", cons_q[i], 8'hC0 + i);

    // High-water mark peak and clear
    do_reset();
    n = 0;
    feed(8, 5, 8'h10, 0, n);
    chk("hwm_fill_count", o_count, 5);
`ifdef FIFO_HWM_EN
    chk("hwm_peak", o_hwm, 5);
`endif
    for (int i = 0; i < 10; i++) begin
      if (mcount() == 2) break;
      feed(1, 5, 8'h10, 1, n);
    end
    chk("hwm_pre_clr_count", o_count, 2);
    m_ready = 1'b0;
    i_hwm_clr = 1'b1;
    step();
    i_hwm_clr = 1'b0;
`ifdef FIFO_HWM_EN
    chk("hwm_cleared", o_hwm, 2);
`else
    chk("hwm_tied", o_hwm, 0);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
